// File: rtl/swipt_rx_pkg.sv
// Shared constants, state encodings and response codes for the SWIPT downlink receiver.
package swipt_rx_pkg;

  localparam int DEF_FIRST_SAMPLE  = 100000;
  localparam int DEF_BIT_PERIOD    = 200000;
  localparam int DEF_START_TIMEOUT = 2000000;
  localparam int DEF_FRAME_BITS    = 36;
  localparam int CSUM_W            = 8;
  localparam int CNT_W             = 6;

  typedef logic [2:0] rx_state_t;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd1;
  localparam logic [2:0] ST_SAMPLE     = 3'd2;
  localparam logic [2:0] ST_CHECK      = 3'd3;
  localparam logic [2:0] ST_RESPOND    = 3'd4;

  typedef enum logic [1:0] {
    RESP_NONE    = 2'b00,
    RESP_CONFIRM = 2'b01,
    RESP_ANSWER  = 2'b10,
    RESP_NACK    = 2'b11
  } resp_kind_e;

  // Queries (mode 00 with type 01/10) get a data answer; anything else is just acknowledged.
  function automatic resp_kind_e good_frame_resp(input logic [1:0] mode,
                                                 input logic [1:0] msg_type);
    if (mode == 2'b00 && (msg_type == 2'b01 || msg_type == 2'b10)) begin
      return RESP_ANSWER;
    end
    return RESP_CONFIRM;
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-sampling timer: loadable down-counter with terminal-count strobe and a
// saturating count of strobes issued in the current frame.
module rx_bit_timer
  import swipt_rx_pkg::*;
#(
  parameter int FIRST_SAMPLE = DEF_FIRST_SAMPLE,
  parameter int BIT_PERIOD   = DEF_BIT_PERIOD,
  parameter int FRAME_BITS   = DEF_FRAME_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_first_i,
  input  logic             run_i,
  input  logic             clear_count_i,
  output logic             strobe_o,
  output logic             last_bit_o,
  output logic [CNT_W-1:0] bit_count_o
);

  localparam int TMR_MAX = (FIRST_SAMPLE > BIT_PERIOD) ? FIRST_SAMPLE : BIT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign strobe_o    = run_i && (timer_q == '0);
  assign last_bit_o  = strobe_o && (count_q == CNT_W'(FRAME_BITS - 1));
  assign bit_count_o = count_q;

  always_comb begin
    timer_d = timer_q;
    if (load_first_i) begin
      timer_d = TMR_W'(FIRST_SAMPLE - 1);
    end else if (strobe_o) begin
      timer_d = TMR_W'(BIT_PERIOD - 1);
    end else if (run_i) begin
      timer_d = timer_q - TMR_W'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear_count_i) begin
      count_d = '0;
    end else if (strobe_o && (count_q < CNT_W'(FRAME_BITS))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      count_q <= '0;
    end else begin
      timer_q <= timer_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rx_frame_sequencer.sv
// SWIPT downlink receive sequencer: start-edge detect, per-bit sample strobes,
// checksum check and uplink response request. RX_TIMEOUT_EN adds a start timeout.
//
// state      | meaning
// IDLE       | window closed, waiting for go
// WAIT_START | window open, waiting for din rising edge
// SAMPLE     | issuing one strobe per bit
// CHECK      | one cycle, checksum compare on rxWord
// RESPOND    | respValid held until respReady
module rx_frame_sequencer
  import swipt_rx_pkg::*;
#(
  parameter int FIRST_SAMPLE  = DEF_FIRST_SAMPLE,
  parameter int BIT_PERIOD    = DEF_BIT_PERIOD,
  parameter int FRAME_BITS    = DEF_FRAME_BITS,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  swiptAlive_i,
  input  logic [1:0]            program_i,
  input  logic                  rxEnable_i,
  input  logic                  din_i,
  input  logic [1:0]            mode_i,
  input  logic [1:0]            type_i,
  input  logic [FRAME_BITS-1:0] rxWord_i,
  output logic                  readDataIn_o,
  output logic                  sampleStrobe_o,
  output logic [CNT_W-1:0]      bitCount_o,
  output logic                  respValid_o,
  output logic [1:0]            respKind_o,
  input  logic                  respReady_i,
  output logic                  frameOk_o,
  output logic                  frameErr_o
);

  rx_state_t   state_q, state_d;
  resp_kind_e  resp_kind_q, resp_kind_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic        din_q;
  logic        go;
  logic        din_rise;
  logic        arm;
  logic        load_first;
  logic        run;
  logic        strobe;
  logic        last_bit;
  logic [CSUM_W-1:0] ones;
  logic        csum_ok;

  assign go       = swiptAlive_i && (program_i == 2'b11) && rxEnable_i;
  assign din_rise = din_i && !din_q;
  assign run      = go && (state_q == ST_SAMPLE);

  rx_bit_timer #(
    .FIRST_SAMPLE (FIRST_SAMPLE),
    .BIT_PERIOD   (BIT_PERIOD),
    .FRAME_BITS   (FRAME_BITS)
  ) u_bit_timer (
    .clk           (clk),
    .rst           (rst),
    .load_first_i  (load_first),
    .run_i         (run),
    .clear_count_i (arm),
    .strobe_o      (strobe),
    .last_bit_o    (last_bit),
    .bit_count_o   (bitCount_o)
  );

  // Checksum is the data-field popcount, wrapping at the field width.
  always_comb begin
    ones = '0;
    for (int i = CSUM_W; i < FRAME_BITS; i++) begin
      ones = ones + {{(CSUM_W-1){1'b0}}, rxWord_i[i]};
    end
  end

  assign csum_ok = (ones == rxWord_i[CSUM_W-1:0]);

`ifdef RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(START_TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (arm) begin
      tmo_d = TMO_W'(START_TIMEOUT - 1);
    end else if ((state_q == ST_WAIT_START) && (tmo_q != '0)) begin
      tmo_d = tmo_q - TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    resp_kind_d = resp_kind_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    arm         = 1'b0;
    load_first  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_WAIT_START;
          arm     = 1'b1;
        end
      end
      ST_WAIT_START: begin
        if (!go) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (din_rise) begin
          state_d    = ST_SAMPLE;
          load_first = 1'b1;
        end
`ifdef RX_TIMEOUT_EN
        else if (tmo_q == '0) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end
`endif
      end
      ST_SAMPLE: begin
        if (!go) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (last_bit) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!go) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else begin
          state_d = ST_RESPOND;
          if (csum_ok) begin
            frame_ok_d  = 1'b1;
            resp_kind_d = good_frame_resp(mode_i, type_i);
          end else begin
            frame_err_d = 1'b1;
            resp_kind_d = RESP_NACK;
          end
        end
      end
      ST_RESPOND: begin
        // Losing the link here only withdraws the request; the frame itself was fine.
        if (!go || respReady_i) begin
          state_d     = ST_IDLE;
          resp_kind_d = RESP_NONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        resp_kind_d = RESP_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      resp_kind_q <= RESP_NONE;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      din_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_kind_q <= resp_kind_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      din_q       <= din_i;
    end
  end

  assign readDataIn_o   = (state_q != ST_IDLE);
  assign respValid_o    = (state_q == ST_RESPOND);
  assign respKind_o     = resp_kind_q;
  assign frameOk_o      = frame_ok_q;
  assign frameErr_o     = frame_err_q;
  assign sampleStrobe_o = strobe;

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Self-checking bench for rx_frame_sequencer: table of frames plus hand-written
// abort, reset and start-timeout sequences, with a response scoreboard.
module tb_rx_frame_sequencer;
  import swipt_rx_pkg::*;

  localparam int FS     = 5;
  localparam int BP     = 10;
  localparam int FB     = 36;
  localparam int TMO    = 50;
  localparam int BUDGET = 400;

  logic          clk;
  logic          rst;
  logic          swiptAlive;
  logic [1:0]    program_sel;
  logic          rxEnable;
  logic          din;
  logic [1:0]    mode;
  logic [1:0]    msg_type;
  logic [FB-1:0] rxWord;
  logic          readDataIn;
  logic          sampleStrobe;
  logic [5:0]    bitCount;
  logic          respValid;
  logic [1:0]    respKind;
  logic          respReady;
  logic          frameOk;
  logic          frameErr;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]    mode;
    logic [1:0]    mtype;
    logic [FB-1:0] word;
    logic [1:0]    kind;
    logic          ok;
    int            stall;
  } vec_t;

  typedef struct {
    logic [1:0] kind;
    logic       ok;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];

  rx_frame_sequencer #(
    .FIRST_SAMPLE  (FS),
    .BIT_PERIOD    (BP),
    .FRAME_BITS    (FB),
    .START_TIMEOUT (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .swiptAlive_i   (swiptAlive),
    .program_i      (program_sel),
    .rxEnable_i     (rxEnable),
    .din_i          (din),
    .mode_i         (mode),
    .type_i         (msg_type),
    .rxWord_i       (rxWord),
    .readDataIn_o   (readDataIn),
    .sampleStrobe_o (sampleStrobe),
    .bitCount_o     (bitCount),
    .respValid_o    (respValid),
    .respKind_o     (respKind),
    .respReady_i    (respReady),
    .frameOk_o      (frameOk),
    .frameErr_o     (frameErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got %0d vectors expected completion", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int outs_packed();
    return int'({readDataIn, sampleStrobe, bitCount, respValid, respKind, frameOk, frameErr});
  endfunction

  task automatic arm_link();
    swiptAlive  = 1'b1;
    program_sel = 2'b11;
    rxEnable    = 1'b1;
    din         = 1'b0;
    @(negedge clk);
    check("arm_read", int'(readDataIn), 1);
    check("arm_count", int'(bitCount), 0);
  endtask

  task automatic run_frame(input vec_t v);
    int k, first, last, nstr, gap_bad, spurious, bad;
    logic got;
    exp_t e;
    mode      = v.mode;
    msg_type  = v.mtype;
    rxWord    = v.word;
    respReady = (v.stall == 0);
    exp_q.push_back('{v.kind, v.ok});
    arm_link();
    din = 1'b1;
    k = 0; first = -1; last = -1; nstr = 0; gap_bad = 0; spurious = 0; got = 1'b0;
    while (k < BUDGET && !got) begin
      @(negedge clk);
      k++;
      if (sampleStrobe) begin
        if (first < 0) first = k;
        else if (k - last != BP) gap_bad++;
        last = k;
        nstr++;
      end
      if (respValid) got = 1'b1;
      else if (frameOk || frameErr) spurious++;
      if (k == 8)  din = 1'b0;
      if (k == 40) din = 1'b1;
      if (k == 45) din = 1'b0;
    end
    check("resp_seen", int'(got), 1);
    check("first_strobe", first, FS);
    check("strobe_gaps", gap_bad, 0);
    check("strobe_count", nstr, FB);
    check("bitcount_final", int'(bitCount), FB);
    check("check_slot", k - last, 2);
    check("spurious_pulse", spurious, 0);
    check("frame_ok", int'(frameOk), int'(v.ok));
    check("frame_err", int'(frameErr), int'(!v.ok));
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("resp_kind", int'(respKind), int'(e.kind));
    end
    if (v.stall > 0) begin
      bad = 0;
      for (int i = 0; i < v.stall; i++) begin
        @(negedge clk);
        if (!respValid || respKind != v.kind || frameOk || frameErr || !readDataIn) bad++;
      end
      check("stall_hold", bad, 0);
      respReady = 1'b1;
    end
    @(negedge clk);
    check("post_resp_read", int'(readDataIn), 0);
    check("post_resp_valid", int'(respValid), 0);
    check("post_resp_kind", int'(respKind), 0);
    rxEnable  = 1'b0;
    respReady = 1'b0;
    @(negedge clk);
  endtask

  task automatic abort_frame(input logic use_program);
    int k, nstr, bad;
    respReady = 1'b1;
    arm_link();
    din = 1'b1;
    k = 0; nstr = 0;
    while (k < BUDGET && nstr < 12) begin
      @(negedge clk);
      k++;
      if (sampleStrobe) nstr++;
    end
    check("abort_strobes", nstr, 12);
    repeat (3) @(negedge clk);
    if (use_program) program_sel = 2'b10;
    else             swiptAlive  = 1'b0;
    @(negedge clk);
    check("abort_err", int'(frameErr), 1);
    check("abort_read", int'(readDataIn), 0);
    check("abort_valid", int'(respValid), 0);
    check("abort_count", int'(bitCount), 12);
    rxEnable = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (respValid || frameErr || frameOk || sampleStrobe || readDataIn) bad++;
    end
    check("abort_quiet", bad, 0);
    swiptAlive  = 1'b1;
    program_sel = 2'b11;
    respReady   = 1'b0;
    din         = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_mid_frame();
    int k, nstr, bad;
    arm_link();
    din = 1'b1;
    k = 0; nstr = 0;
    while (k < BUDGET && nstr < 3) begin
      @(negedge clk);
      k++;
      if (sampleStrobe) nstr++;
    end
    rst      = 1'b1;
    rxEnable = 1'b0;
    din      = 1'b0;
    @(negedge clk);
    check("rst_outputs", outs_packed(), 0);
    rst = 1'b0;
    din = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (readDataIn || sampleStrobe || frameErr) bad++;
    end
    check("rst_edge_ignored", bad, 0);
    din      = 1'b0;
    rxEnable = 1'b1;
    @(negedge clk);
    check("rst_rearm", int'(readDataIn), 1);
    din = 1'b1;
    k = 0;
    while (k < BUDGET && !sampleStrobe) begin
      @(negedge clk);
      k++;
    end
    check("rst_first_strobe", k, FS);
    rxEnable = 1'b0;
    @(negedge clk);
    check("rst_abort_err", int'(frameErr), 1);
    din = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_timeout();
    int first_err, errs;
    logic rd_at_err, rd_after;
    din        = 1'b0;
    swiptAlive = 1'b1;
    program_sel = 2'b11;
    rxEnable   = 1'b1;
`ifdef RX_TIMEOUT_EN
    first_err = -1;
    rd_at_err = 1'b1;
    rd_after  = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (first_err >= 0 && k == first_err + 1) rd_after = readDataIn;
      if (frameErr && first_err < 0) begin
        first_err = k;
        rd_at_err = readDataIn;
      end
    end
    check("tmo_err_cycle", first_err, TMO + 1);
    check("tmo_read_drop", int'(rd_at_err), 0);
    check("tmo_rearm", int'(rd_after), 1);
`else
    errs = 0;
    first_err = 0;
    rd_at_err = 1'b0;
    rd_after  = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (frameErr || !readDataIn) errs++;
    end
    check("no_tmo_errs", errs + first_err + int'(rd_at_err) + int'(rd_after), 0);
    check("no_tmo_waiting", int'(readDataIn), 1);
`endif
    rxEnable = 1'b0;
    @(negedge clk);
    check("tmo_abort_err", int'(frameErr), 1);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{2'b00, 2'b01, {28'h0001FFF, 8'h0D}, RESP_ANSWER,  1'b1, 20};
    vecs[1] = '{2'b01, 2'b01, {28'h0001FFF, 8'h0D}, RESP_CONFIRM, 1'b1, 0};
    vecs[2] = '{2'b00, 2'b01, {28'h0001FFF, 8'h0C}, RESP_NACK,    1'b0, 0};
    vecs[3] = '{2'b00, 2'b10, {28'hFFFFFFF, 8'h1C}, RESP_ANSWER,  1'b1, 0};
    vecs[4] = '{2'b00, 2'b11, {28'h0000000, 8'h00}, RESP_CONFIRM, 1'b1, 0};
    vecs[5] = '{2'b00, 2'b00, {28'hA5A5A5A, 8'h0E}, RESP_CONFIRM, 1'b1, 0};
    vecs[6] = '{2'b10, 2'b10, {28'h8000001, 8'hFF}, RESP_NACK,    1'b0, 0};
    vecs[7] = '{2'b11, 2'b01, {28'h8000001, 8'h02}, RESP_CONFIRM, 1'b1, 0};

    rst         = 1'b1;
    swiptAlive  = 1'b0;
    program_sel = 2'b00;
    rxEnable    = 1'b0;
    din         = 1'b0;
    mode        = 2'b00;
    msg_type    = 2'b00;
    rxWord      = '0;
    respReady   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_packed(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs_packed(), 0);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i]);
    end
    check("scoreboard_drained", exp_q.size(), 0);

    mode     = 2'b00;
    msg_type = 2'b01;
    rxWord   = {28'h0001FFF, 8'h0D};
    abort_frame(1'b0);
    abort_frame(1'b1);
    reset_mid_frame();
    start_timeout();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_frame_sequencer.md
# rx_frame_sequencer

Controls the SWIPT downlink receive path when `program` = 2'b11. It opens the read window, detects the start edge on `din`, and issues one sample strobe per bit to the bit-capture datapath. After 36 bits it checks the frame checksum and requests the matching uplink response: confirmation, answer or NACK. It sits between the top-level program controller and the bit-capture/shift datapath.

## Interface
Parameters:
- `FIRST_SAMPLE`, 100000: cycles from start-edge detection to the first sample strobe (half bit).
- `BIT_PERIOD`, 200000: cycles between subsequent sample strobes.
- `FRAME_BITS`, 36: bits per frame. The low 8 bits are the checksum field.
- `START_TIMEOUT`, 2000000: cycles allowed in WAIT_START (used only with `RX_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `swiptAlive`  in  1  link present. Low aborts any frame.
- `program`  in  2  active program. Only 2'b11 permits reception.
- `rxEnable`  in  1  level request to listen for a frame.
- `din`  in  1  downlink bit, already synchronised to `clk`.
- `mode`  in  2  current mode. Sampled in CHECK.
- `type`  in  2  message type. Sampled in CHECK.
- `rxWord`  in  36  datapath shift register, MSB first in.
- `readDataIn`  out  1  read window to the datapath.
- `sampleStrobe`  out  1  one-cycle pulse: the datapath shifts in `din`.
- `bitCount`  out  6  strobes issued in the current frame.
- `respValid`  out  1  response request.
- `respKind`  out  2  01 CONFIRM, 10 ANSWER, 11 NACK, 00 none.
- `respReady`  in  1  response consumer accepts.
- `frameOk`  out  1  one-cycle pulse on a good checksum.
- `frameErr`  out  1  one-cycle pulse on bad checksum, abort or timeout.

## Operation
- Enable condition, "go": `swiptAlive` & (`program` == 2'b11) & `rxEnable`.
- Reset: state IDLE. Every output is 0. Counters are cleared.
- IDLE → WAIT_START when go is high. `readDataIn` rises in the same transition.
- WAIT_START → SAMPLE on a `din` rising edge (`din` & ~`din_q`). The timer loads `FIRST_SAMPLE`-1.
- SAMPLE behaviour:
  - When the timer reaches 0: pulse `sampleStrobe`, increment `bitCount`, reload `BIT_PERIOD`-1.
  - After strobe number `FRAME_BITS`, go to CHECK.
- CHECK lasts one cycle.
  - `popcount(rxWord[35:8])` mod 256 is compared with `rxWord[7:0]`.
  - Match: pulse `frameOk`. `respKind` = ANSWER if `mode`==00 and `type`∈{01,10}, otherwise CONFIRM.
  - Mismatch: pulse `frameErr`. `respKind` = NACK.
  - Next state is RESPOND.
- RESPOND:
  - `respValid` holds, with `respKind` stable, until `respValid`&`respReady`.
  - Then go to IDLE. `readDataIn`, `respValid` and `respKind` clear.
- Abort: go low in WAIT_START, SAMPLE or CHECK.
  - Go to IDLE on the next edge. `frameErr` pulses. No response is issued.
  - In RESPOND an abort only drops `respValid`, with no `frameErr`.
- `din` edges outside WAIT_START are ignored. Only one frame per window.

## Timing
- `readDataIn` is high from the cycle after go is detected until the cycle after the handshake or abort.
- First strobe: exactly `FIRST_SAMPLE` cycles after the cycle the edge was registered.
- Later strobes: spaced exactly `BIT_PERIOD` cycles apart.
- CHECK is the cycle after the final strobe. `rxWord` is valid there because the datapath updated on the strobe edge.
- `respValid` rises the cycle after CHECK.
- Back-to-back: `respReady` held high gives a one-cycle RESPOND.
- `rst` mid-frame takes priority over everything. State is IDLE and all outputs are 0 on the next edge.
- `bitCount` saturates at `FRAME_BITS`. It is cleared on entry to WAIT_START.

## Configuration
- `RX_TIMEOUT_EN` defined:
  - A counter runs in WAIT_START.
  - After `START_TIMEOUT` cycles with no edge: pulse `frameErr`, go to IDLE, drop `readDataIn`.
  - If go is still high, the block re-arms on the following cycle.
- Not defined: WAIT_START waits indefinitely and no timeout counter is synthesised.

## Structure
- Package `swipt_rx_pkg`:
  - state enum (IDLE, WAIT_START, SAMPLE, CHECK, RESPOND)
  - `respKind` constants RESP_NONE/CONFIRM/ANSWER/NACK
  - default `FIRST_SAMPLE`/`BIT_PERIOD` values
  - `FRAME_BITS` and checksum width 8
- Sub-module `rx_bit_timer`:
  - loadable down-counter
  - load value select (first/period)
  - terminal-count strobe
  - `bitCount` tracking

## Test plan
Simulate with `FIRST_SAMPLE`=5, `BIT_PERIOD`=10.
- Good frame, `mode`=00, `type`=01, `rxWord` = 28 data bits with 13 ones and checksum 8'h0D: `frameOk` pulses; `respKind`=ANSWER; first strobe 5 cycles after the edge; 36 strobes 10 cycles apart.
- Same frame with `mode`=01: `respKind`=CONFIRM. With checksum 8'h0C: `frameErr` pulses and `respKind`=NACK.
- `respReady` held low for 20 cycles: `respValid` and `respKind` stay stable; IDLE one cycle after `respReady` rises.
- `swiptAlive` drops after strobe 12: `frameErr` pulses; `readDataIn`=0 next cycle; no `respValid`. Repeat with `program`=2'b10.
- `rst` asserted during SAMPLE: all outputs 0 next cycle; a new edge is ignored until go re-arms.
- With `RX_TIMEOUT_EN` and `START_TIMEOUT`=50, no `din` edge: `frameErr` at cycle 50; re-arm on the following cycle. Without the macro, still in WAIT_START at cycle 1000.
